// File: rtl/alu_regfile_wb.sv
// alu_regfile_wb: operand-fetch/writeback stage around alu16 with a register file and PSR
//   clk, rst            : clock, synchronous active-high reset
//   in_*                : instruction handshake and payload (accepted only in IDLE)
//   alu_*               : registered operands/opcode to alu16, its result and raw flags back
//   psr, done, err      : status register, retire pulse, timeout-retire pulse
//   dbg_addr, dbg_data  : asynchronous read of committed register state
module alu_regfile_wb #(
  parameter int NREGS   = 16,
  parameter int TIMEOUT = 8,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [AW-1:0] in_rdest,
  input  logic [AW-1:0] in_rsrc,
  input  logic          in_use_imm,
  input  logic [15:0]   in_imm,
  input  logic [4:0]    in_shamt,
  input  logic          in_wb_en,
  input  logic [4:0]    in_flags_sel,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [4:0]    alu_op,
  output logic [4:0]    alu_shamt,
  output logic          alu_psr_c,
  input  logic [15:0]   alu_y,
  input  logic          alu_y_valid,
  input  logic [4:0]    alu_flags_raw,
  output logic [4:0]    psr,
  output logic          done,
  output logic          err,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t        r_state;
  logic [15:0]   r_regs [NREGS];
  logic [4:0]    r_psr;
  logic [AW-1:0] r_rdest;
  logic          r_wb_en;
  logic [4:0]    r_sel;
  logic [15:0]   r_y;
  logic [4:0]    r_f;
  logic          r_abort;
  logic [CW-1:0] r_cnt;
  assign in_ready  = r_state == IDLE;
  assign done      = r_state == WB;
  assign err       = done & r_abort;
  assign psr       = r_psr;
  assign alu_psr_c = r_psr[4];
  assign dbg_data  = r_regs[dbg_addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_psr     <= '0;
      r_rdest   <= '0;
      r_wb_en   <= 1'b0;
      r_sel     <= '0;
      r_y       <= '0;
      r_f       <= '0;
      r_abort   <= 1'b0;
      r_cnt     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_shamt <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_rdest   <= in_rdest;
          r_wb_en   <= in_wb_en;
          r_sel     <= in_flags_sel;
          r_abort   <= 1'b0;
          r_cnt     <= '0;
          alu_a     <= r_regs[in_rdest];
          alu_b     <= in_use_imm ? in_imm : r_regs[in_rsrc];
          alu_op    <= in_op;
          alu_shamt <= in_shamt;
          r_state   <= EXEC;
        end
        EXEC: if (alu_y_valid) begin
          r_y     <= alu_y;
          r_f     <= alu_flags_raw;
          r_state <= WB;
        end else if (r_cnt == LAST) begin
          r_abort <= 1'b1;
          r_state <= WB;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        WB: begin
          if (!r_abort) begin
            if (r_wb_en) r_regs[r_rdest] <= r_y;
            r_psr <= (r_psr & ~r_sel) | (r_f & r_sel);
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_regfile_wb.sv
// tb_alu_regfile_wb: randomized scoreboard bench with an alu16 stand-in and a register-file reference model
module tb_alu_regfile_wb;
  localparam int TIMEOUT = 8;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_use_imm = 0, in_wb_en = 0;
  logic [4:0] in_op = 0, in_shamt = 0, in_flags_sel = 0;
  logic [3:0] in_rdest = 0, in_rsrc = 0;
  logic [15:0] in_imm = 0;
  logic [15:0] alu_a, alu_b, alu_y, dbg_data;
  logic [4:0] alu_op, alu_shamt, alu_flags_raw, psr;
  logic alu_psr_c, alu_y_valid, done, err;
  logic [3:0] dbg_addr, dbg_addr_m = 0, dbg_addr_s = 0;
  logic dbg_m = 0, alu_en = 1;
  logic [20:0] w_alu;
  int errs = 0, checks = 0, cyc = 0, n_acc = 0;
  typedef struct {
    logic err; int acc; logic [15:0] a, b; logic [4:0] op; logic c_in;
    logic [3:0] rd; logic [15:0] rval; logic [4:0] psr;
  } exp_t;
  exp_t q[$];
  logic [15:0] m_r [16];
  logic [4:0] m_psr;
  always #5 clk = ~clk;
  alu_regfile_wb #(.NREGS(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rdest(in_rdest), .in_rsrc(in_rsrc), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_shamt(in_shamt), .in_wb_en(in_wb_en), .in_flags_sel(in_flags_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt), .alu_psr_c(alu_psr_c),
    .alu_y(alu_y), .alu_y_valid(alu_y_valid), .alu_flags_raw(alu_flags_raw),
    .psr(psr), .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  function automatic logic [20:0] alu_fn(input logic [4:0] op, input logic [15:0] a, b, input logic [4:0] sh);
    logic [16:0] s;
    logic v;
    s = {1'b0, a} + {1'b0, b};
    v = (a[15] == b[15]) && (s[15] != a[15]);
    if (op == 8 || op == 10) begin
      s = {1'b0, a} - {1'b0, b};
      v = (a[15] != b[15]) && (s[15] != a[15]);
    end else if (op == 14) begin s = {1'b0, a & b}; v = 0; end
    else if (op == 16) begin s = {1'b0, a | b}; v = 0; end
    else if (op == 18) begin s = {1'b0, a ^ b}; v = 0; end
    else if (op == 20) begin s = {1'b0, ~a}; v = 0; end
    else if (op == 21) begin s = {1'b0, a} << sh; v = 0; end
    return {s[15:0], s[16], v, s[15:0] == 16'h0, a < b, $signed(a) < $signed(b)};
  endfunction
  assign w_alu = alu_fn(alu_op, alu_a, alu_b, alu_shamt);
  assign alu_y = w_alu[20:5];
  assign alu_flags_raw = w_alu[4:0];
  assign alu_y_valid = alu_en;
  assign dbg_addr = dbg_m ? dbg_addr_m : dbg_addr_s;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      foreach (m_r[i]) m_r[i] = 0;
      m_psr = 0;
    end else if (in_valid && in_ready) begin
      exp_t e;
      logic [20:0] r;
      logic [15:0] b;
      n_acc++;
      b = in_use_imm ? in_imm : m_r[in_rsrc];
      r = alu_fn(in_op, m_r[in_rdest], b, in_shamt);
      e.err = !alu_en; e.acc = cyc; e.a = m_r[in_rdest]; e.b = b; e.op = in_op;
      e.c_in = m_psr[4]; e.rd = in_rdest;
      if (alu_en) begin
        if (in_wb_en) m_r[in_rdest] = r[20:5];
        m_psr = (m_psr & ~in_flags_sel) | (r[4:0] & in_flags_sel);
      end
      e.rval = m_r[in_rdest]; e.psr = m_psr;
      q.push_back(e);
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (err && !done) chk("err_without_done", err, 0);
      if (done) begin
        if (q.size() == 0) chk("done_with_nothing_pending", done, 0);
        else begin
          e = q.pop_front();
          chk("err", err, e.err);
          chk("latency", cyc - e.acc, e.err ? TIMEOUT : 1);
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
          chk("alu_op", alu_op, e.op);
          chk("alu_psr_c", alu_psr_c, e.c_in);
          chk("ready_busy", in_ready, 0);
          @(posedge clk);
          #1 dbg_addr_m = e.rd; dbg_m = 1;
          #1 chk("reg", dbg_data, e.rval);
          chk("psr", psr, e.psr);
          dbg_m = 0;
        end
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk("idle_reached", in_ready, 1);
  endtask
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, rs, input logic ui,
                       input logic [15:0] imm, input logic [4:0] sh, input logic wb, input logic [4:0] sel);
    @(negedge clk);
    in_op = op; in_rdest = rd; in_rsrc = rs; in_use_imm = ui; in_imm = imm;
    in_shamt = sh; in_wb_en = wb; in_flags_sel = sel; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wait_idle();
  endtask
  task automatic rand_payload();
    logic [4:0] ops [8] = '{5'd0, 5'd8, 5'd10, 5'd14, 5'd16, 5'd18, 5'd20, 5'd21};
    in_op = ops[$urandom_range(0, 7)]; in_rdest = 4'($urandom); in_rsrc = 4'($urandom);
    in_use_imm = 1'($urandom); in_imm = 16'($urandom); in_shamt = 5'($urandom_range(0, 16));
    in_wb_en = in_op != 10; in_flags_sel = 5'($urandom);
  endtask
  initial begin
    int a0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_psr", psr, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    issue(5'd0, 4'd1, 4'd0, 1, 16'd5, 0, 1, 5'b11111);
    dbg_addr_s = 1;
    #1 chk("t1_r1", dbg_data, 16'h0005);
    chk("t1_psr", psr, 5'b00011);
    issue(5'd8, 4'd1, 4'd0, 1, 16'd16, 0, 1, 5'b00100);
    #1 chk("t2_r1", dbg_data, 16'hFFF5);
    chk("t2_psr", psr, 5'b00011);
    issue(5'd10, 4'd1, 4'd0, 1, 16'hFFF5, 0, 0, 5'b11111);
    #1 chk("t3_r1", dbg_data, 16'hFFF5);
    chk("t3_psr", psr, 5'b00100);
    a0 = n_acc;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rand_payload();
      in_valid = 1;
    end
    @(negedge clk);
    in_valid = 0;
    wait_idle();
    chk("t4_captures", n_acc - a0, 3);
    alu_en = 0;
    issue(5'd0, 4'd3, 4'd0, 1, 16'd9, 0, 1, 5'b11111);
    alu_en = 1;
    for (int i = 0; i < 60; i++) begin
      alu_en = $urandom_range(0, 7) != 0;
      @(negedge clk);
      rand_payload();
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      wait_idle();
      alu_en = 1;
    end
    alu_en = 0;
    @(negedge clk);
    in_op = 0; in_rdest = 2; in_use_imm = 1; in_imm = 7; in_wb_en = 1; in_flags_sel = 5'b11111;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    alu_en = 1;
    chk("t6_ready", in_ready, 1);
    chk("t6_done", done, 0);
    chk("t6_psr", psr, 0);
    chk("t6_alu_b", alu_b, 0);
    dbg_addr_s = 2;
    #1 chk("t6_r2", dbg_data, 0);
    repeat (TIMEOUT + 4) @(negedge clk);
    chk("pending_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
